lo_commutating_demod: RTL and testbench
=======================================

Name: lo_commutating_demod

Overview:
- Digital receive-side counterpart of the switching-quad active mixer. It takes the sampled, digitised mixer IF output and multiplies it by a square-wave local oscillator (LO), as the analog switching pair does. It then integrates and dumps over DECIM samples to recover the baseband/RF envelope.
- Sits between the IF ADC sample stream and the downstream baseband processing.
- Output uses a valid/ready handshake.

Parameters:
- DATA_W, 16, signed input sample width.
- PHASE_W, 24, LO phase-accumulator width.
- DECIM, 64, accepted samples per integrate-and-dump frame; must be ≥2.
- ACC_W (derived), DATA_W+1+clog2(DECIM), accumulator and output width; not overridable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  run control; when low, input samples are ignored.
- phase_inc  in  PHASE_W  LO phase increment per accepted sample (unsigned).
- phase_sync  in  1  one-cycle pulse that restarts the LO phase and the current frame.
- in_valid  in  1  qualifies in_data; no backpressure is applied to the input.
- in_data  in  DATA_W  signed IF sample.
- out_valid  out  1  a dumped result is held on out_data.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid && out_ready.
- out_data  out  ACC_W  signed integrated result.
- lo_out  out  1  current LO polarity (phase MSB), for monitoring.
- overrun  out  1  sticky flag: a frame result was dropped.

Behaviour:
- Reset (rst_n low at a clock edge): phase=0, acc=0, count=0, out_valid=0, out_data=0, overrun=0, lo_out=0, state=IDLE. Reset wins over every other input. A frame interrupted by reset is discarded.
- States:
  - IDLE: entered when enable=0. In_valid is ignored; phase, acc and count hold. The output handshake stays live.
  - RUN: entered when enable=1, in the next cycle. Returning to enable=0 goes back to IDLE, with the partial frame preserved.
- Accept condition: state==RUN && in_valid && !phase_sync.
- Product: lo = phase[PHASE_W-1]. The product is +in_data when lo=0 and −in_data when lo=1. It is computed at DATA_W+1 bits, so −(−2^(DATA_W−1)) is exact with no saturation.
- On accept:
  - phase += phase_inc, modulo 2^PHASE_W (wraps naturally).
  - acc += sign-extended product.
  - count += 1.
- Dump: when an accept happens with count==DECIM−1:
  - acc+product is the frame result.
  - acc and count are cleared to 0 in the same edge.
  - The result appears on out_data with out_valid=1 on the cycle after the last sample edge (1-cycle latency).
  - Back-to-back frames are not blocked by the dump.
- Output register and simultaneous events:
  - If out_valid=0, or out_valid && out_ready, in the dump cycle: the new result is loaded and out_valid=1.
  - If out_valid && !out_ready in the dump cycle: the new result is discarded, the held value is unchanged, and overrun is set.
  - A transfer with no dump in the same cycle: out_valid goes to 0 next cycle; out_data keeps its last value.
- phase_sync:
  - Clears phase, acc, count and overrun next cycle.
  - Has priority over a same-cycle in_valid; that sample is dropped and not accumulated.
  - Does not touch out_valid or out_data.
- lo_out: registered copy of phase MSB, updated with phase.
- Range: ACC_W never overflows for DECIM samples of full-scale input.

Test Plan:
- Alternating LO: DECIM=4, DATA_W=16, phase_inc=2^23. Inputs 100,−100,100,−100 → out_data=400 one cycle after the 4th accept; lo_out toggles 0,1,0,1. Inputs 100×4 → out_data=0.
- DC LO: phase_inc=0, inputs 1,2,3,4 → out_data=10, lo_out=0. Then force phase MSB via phase_inc=2^23 after phase_sync, inputs −32768×4 (lo pattern 0,1,0,1) → out_data=0. With phase pre-advanced to lo=1 and phase_inc=0, inputs −32768×4 → out_data=+131072 with no wrap (ACC_W=19).
- Backpressure: hold out_ready=0 across two frames (first result=10) → out_data stays 10 and overrun=1. Assert phase_sync → overrun=0 while out_valid stays 1.
- Simultaneous dump and transfer: out_ready=1 in the dump cycle of frame 2 → out_valid stays 1 and out_data updates to the frame-2 value with no gap; overrun=0.
- Enable/sync edge cases:
  - Drop enable after 2 of 4 samples, idle 10 cycles, re-enable and feed 2 more → a single correct dump.
  - phase_sync coincident with in_valid → that sample is excluded.
- Reset mid-frame: pulse rst_n low after 3 samples with out_valid=1 → all outputs 0 next cycle, and the following 4 samples produce a fresh result.

Source files
------------

// File: rtl/lo_commutating_demod.sv
// Square-wave LO commutating demodulator: multiplies IF samples by +/-1 from an
// NCO phase MSB, then integrates and dumps every DECIM accepted samples.
module lo_commutating_demod #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24,
  parameter int DECIM   = 64,
  localparam int ACC_W  = DATA_W + 1 + $clog2(DECIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic                      phase_sync,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_data,
  output logic                      lo_out,
  output logic                      overrun
);

  localparam int CNT_W = $clog2(DECIM);
  localparam int EXT_W = ACC_W - DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]               state_q,     state_d;
  logic [PHASE_W-1:0]       phase_q,     phase_d;
  logic signed [ACC_W-1:0]  acc_q,       acc_d;
  logic [CNT_W-1:0]         count_q,     count_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_data_q,  out_data_d;
  logic                     lo_q,        lo_d;
  logic                     overrun_q,   overrun_d;

  logic                     accept;
  logic                     dump;
  logic                     xfer;
  logic signed [DATA_W:0]   sample_ext;
  logic signed [DATA_W:0]   product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  frame_sum;

  // Product is one bit wider than the sample so negating the most negative input is exact.
  always_comb begin
    accept      = (state_q == ST_RUN) && in_valid && !phase_sync;
    sample_ext  = {in_data[DATA_W-1], in_data};
    product     = phase_q[PHASE_W-1] ? -sample_ext : sample_ext;
    product_ext = {{EXT_W{product[DATA_W]}}, product};
    frame_sum   = acc_q + product_ext;
    dump        = accept && (count_q == LAST_CNT);
    xfer        = out_valid_q && out_ready;
  end

  always_comb begin
    state_d     = enable ? ST_RUN : ST_IDLE;
    phase_d     = phase_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    if (phase_sync) begin
      phase_d   = '0;
      acc_d     = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      phase_d = phase_q + phase_inc;
      if (dump) begin
        acc_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = frame_sum;
        count_d = count_q + CNT_W'(1);
      end
    end

    // A dump into a stalled output register is dropped and flagged rather than stalling frames.
    if (dump) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = frame_sum;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    lo_d = phase_d[PHASE_W-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      lo_q        <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      lo_q        <= lo_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign lo_out    = lo_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lo_commutating_demod.sv
// Directed bench for lo_commutating_demod with DECIM=4; expected values are hand-computed.
module tb_lo_commutating_demod;

  localparam int DATA_W  = 16;
  localparam int PHASE_W = 24;
  localparam int DECIM   = 4;
  localparam int ACC_W   = DATA_W + 1 + $clog2(DECIM);

  logic                     clk;
  logic                     rst_n;
  logic                     enable;
  logic [PHASE_W-1:0]       phase_inc;
  logic                     phase_sync;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     lo_out;
  logic                     overrun;

  int n_vec  = 0;
  int n_fail = 0;

  lo_commutating_demod #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W),
    .DECIM   (DECIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .phase_inc  (phase_inc),
    .phase_sync (phase_sync),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lo_out     (lo_out),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    in_valid = 1'b1;
    in_data  = DATA_W'(s);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_lo(input string tag, input int s, input int exp_lo);
    check_eq(tag, longint'(lo_out), longint'(exp_lo));
    send(s);
  endtask

  task automatic sync_pulse();
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
  endtask

  function automatic longint od();
    return longint'($signed(out_data));
  endfunction

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    phase_inc  = '0;
    phase_sync = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_data", od(), 0);
    check_eq("rst_overrun", longint'(overrun), 0);
    check_eq("rst_lo_out", longint'(lo_out), 0);
    rst_n = 1'b1;

    // Alternating LO: sign flips cancel the input alternation
    phase_inc = 24'h800000;
    enable    = 1'b1;
    tick();
    send_lo("alt_lo0", 100, 0);
    send_lo("alt_lo1", -100, 1);
    send_lo("alt_lo2", 100, 0);
    send_lo("alt_lo3", -100, 1);
    check_eq("alt_valid", longint'(out_valid), 1);
    check_eq("alt_data", od(), 400);
    send(100); send(100); send(100); send(100);
    check_eq("alt_dc_valid", longint'(out_valid), 1);
    check_eq("alt_dc_data", od(), 0);

    // DC LO
    phase_inc = '0;
    sync_pulse();
    send_lo("dc_lo0", 1, 0);
    send(2); send(3); send(4);
    check_eq("dc_data", od(), 10);
    check_eq("dc_lo_end", longint'(lo_out), 0);

    phase_inc = 24'h800000;
    sync_pulse();
    send_lo("neg_lo0", -32768, 0);
    send_lo("neg_lo1", -32768, 1);
    send(-32768); send(-32768);
    check_eq("neg_alt_data", od(), 0);

    // Advance phase to lo=1 via a zero-valued frame (4*0x600000 mod 2^24 = 0x800000)
    phase_inc = 24'h600000;
    sync_pulse();
    send(0); send(0); send(0); send(0);
    check_eq("pre_adv_lo", longint'(lo_out), 1);
    phase_inc = '0;
    send(-32768); send(-32768); send(-32768); send(-32768);
    check_eq("fullscale_data", od(), 131072);
    check_eq("fullscale_lo", longint'(lo_out), 1);

    // Backpressure and overrun
    sync_pulse();
    check_eq("drain_valid", longint'(out_valid), 0);
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    check_eq("bp_first_valid", longint'(out_valid), 1);
    check_eq("bp_first_data", od(), 10);
    check_eq("bp_first_ovr", longint'(overrun), 0);
    send(5); send(5); send(5); send(5);
    check_eq("bp_hold_data", od(), 10);
    check_eq("bp_overrun", longint'(overrun), 1);
    sync_pulse();
    check_eq("sync_ovr_clr", longint'(overrun), 0);
    check_eq("sync_valid_kept", longint'(out_valid), 1);
    check_eq("sync_data_kept", od(), 10);

    // Dump coincident with transfer
    send(1); send(2); send(3);
    out_ready = 1'b1;
    send(9);
    check_eq("sim_valid", longint'(out_valid), 1);
    check_eq("sim_data", od(), 15);
    check_eq("sim_ovr", longint'(overrun), 0);
    tick();
    check_eq("xfer_valid", longint'(out_valid), 0);
    check_eq("xfer_data_kept", od(), 15);

    // Enable drop mid-frame; samples while idle are ignored
    send(10); send(20);
    enable = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 16'sd999;
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    check_eq("idle_no_dump", longint'(out_valid), 0);
    enable = 1'b1;
    tick();
    send(30);
    check_eq("resume_no_early", longint'(out_valid), 0);
    send(40);
    check_eq("resume_valid", longint'(out_valid), 1);
    check_eq("resume_data", od(), 100);
    tick();

    // phase_sync wins over a same-cycle sample
    send(1); send(2);
    in_valid   = 1'b1;
    in_data    = 16'sd1000;
    phase_sync = 1'b1;
    tick();
    in_valid   = 1'b0;
    phase_sync = 1'b0;
    send(1); send(2); send(3);
    check_eq("sync_excl_nodump", longint'(out_valid), 0);
    out_ready = 1'b0;
    send(4);
    check_eq("sync_excl_data", od(), 10);

    // Reset mid-frame with a held result
    phase_inc = 24'h800000;
    send(5); send(5); send(5);
    check_eq("pre_rst_lo", longint'(lo_out), 1);
    check_eq("pre_rst_valid", longint'(out_valid), 1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", longint'(out_valid), 0);
    check_eq("mid_rst_data", od(), 0);
    check_eq("mid_rst_lo", longint'(lo_out), 0);
    check_eq("mid_rst_ovr", longint'(overrun), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    phase_inc = '0;
    tick();
    send(2); send(4); send(6); send(8);
    check_eq("post_rst_valid", longint'(out_valid), 1);
    check_eq("post_rst_data", od(), 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
